// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-control receive sequencer.
// Holds the FSM state encoding, frame command codes, the RF addresses
// used as ALU operands and the default response timeout.
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        RD_WAIT  = 4'd4,
        OP_A     = 4'd5,
        OP_B     = 4'd6,
        OP_FUN   = 4'd7,
        ALU_WAIT = 4'd8,
        TX_RD    = 4'd9,
        TX_LO    = 4'd10,
        TX_HI    = 4'd11
    } state_t;

    // First byte of a frame selects the command
    localparam logic [7:0] CMD_WR      = 8'hAA;  // addr, data
    localparam logic [7:0] CMD_RD      = 8'hBB;  // addr
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // A, B, fun
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // fun

    // The ALU always reads its operands from these register-file slots
    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    localparam int WAIT_MAX_DEF = 255;
    localparam int WAIT_CNT_W   = 8;

endpackage

// File: rtl/sys_ctrl_rx.sv
// Purpose : decode UART RX command frames into RF writes/reads and ALU ops, return results to UART TX.
// Latency : every output registered; strobes one cycle after the triggering RX byte, TX byte one cycle after RF/ALU valid.
// Backpressure: TX_D_VLD and TX_P_DATA hold while TX_BUSY=1; RX bytes arriving while waiting or transmitting are dropped.
//
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD/RX_ERR         byte stream from the UART receiver
//   RF_ADDR/RF_WR_EN/RF_WR_DATA       register-file write port
//   RF_RD_EN/RF_RD_DATA/RF_RD_VLD     register-file read port
//   ALU_EN/ALU_FUN/ALU_OUT/ALU_OUT_VLD ALU command and result
//   CLK_GATE_EN                       ALU clock-gate enable
//   TX_P_DATA/TX_D_VLD/TX_BUSY        byte handoff to the UART transmitter
//   CMD_ERR                           one-cycle pulse on any frame abort
module sys_ctrl_rx
    import sys_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int FUN_W    = 4,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [DATA_W-1:0]   RX_P_DATA,
    input  logic                RX_D_VLD,
    input  logic                RX_ERR,
    output logic [ADDR_W-1:0]   RF_ADDR,
    output logic                RF_WR_EN,
    output logic [DATA_W-1:0]   RF_WR_DATA,
    output logic                RF_RD_EN,
    input  logic [DATA_W-1:0]   RF_RD_DATA,
    input  logic                RF_RD_VLD,
    output logic                ALU_EN,
    output logic [FUN_W-1:0]    ALU_FUN,
    input  logic [2*DATA_W-1:0] ALU_OUT,
    input  logic                ALU_OUT_VLD,
    output logic                CLK_GATE_EN,
    output logic [DATA_W-1:0]   TX_P_DATA,
    output logic                TX_D_VLD,
    input  logic                TX_BUSY,
    output logic                CMD_ERR
);

    state_t                  state, nxt;
    logic [ADDR_W-1:0]       wr_addr;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]       alu_hi;

    logic byte_ok, byte_err, tx_acc, in_wait, timeout, bad_cmd, abort;

    // Next-cycle values of the registered outputs
    logic [ADDR_W-1:0] rf_addr_d;
    logic [DATA_W-1:0] rf_wr_data_d, tx_data_d, alu_hi_d;
    logic [FUN_W-1:0]  alu_fun_d;
    logic              rf_wr_en_d, rf_rd_en_d, alu_en_d, gate_d, tx_vld_d, cmd_err_d;

    assign byte_ok  = RX_D_VLD & ~RX_ERR;
    assign byte_err = RX_D_VLD & RX_ERR;
    assign tx_acc   = TX_D_VLD & ~TX_BUSY;
    assign in_wait  = (state == RD_WAIT) || (state == ALU_WAIT);

    // A response arriving in the last allowed cycle wins over the timeout
    assign timeout = (((state == RD_WAIT) && !RF_RD_VLD) ||
                      ((state == ALU_WAIT) && !ALU_OUT_VLD)) &&
                     (wait_cnt == WAIT_CNT_W'(WAIT_MAX - 1));

    assign bad_cmd = (state == IDLE) && byte_ok &&
                     (RX_P_DATA != CMD_WR) && (RX_P_DATA != CMD_RD) &&
                     (RX_P_DATA != CMD_ALU_OP) && (RX_P_DATA != CMD_ALU_NOP);

    // All abort causes merge here, so coincident causes give one CMD_ERR pulse
    assign abort = byte_err | timeout | bad_cmd;

    // State register, wait counter and frame address latch
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wr_addr  <= '0;
        end else begin
            state <= nxt;
            // Held at zero outside the wait states, so it starts at zero on entry
            if (!in_wait)
                wait_cnt <= '0;
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == WR_ADDR && byte_ok)
                wr_addr <= RX_P_DATA[ADDR_W-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (byte_ok) begin
                    case (RX_P_DATA)
                        CMD_WR:      nxt = WR_ADDR;
                        CMD_RD:      nxt = RD_ADDR;
                        CMD_ALU_OP:  nxt = OP_A;
                        CMD_ALU_NOP: nxt = OP_FUN;
                        default:     nxt = IDLE;
                    endcase
                end
                WR_ADDR:  if (byte_ok)     nxt = WR_DATA;
                WR_DATA:  if (byte_ok)     nxt = IDLE;
                RD_ADDR:  if (byte_ok)     nxt = RD_WAIT;
                RD_WAIT:  if (RF_RD_VLD)   nxt = TX_RD;
                OP_A:     if (byte_ok)     nxt = OP_B;
                OP_B:     if (byte_ok)     nxt = OP_FUN;
                OP_FUN:   if (byte_ok)     nxt = ALU_WAIT;
                ALU_WAIT: if (ALU_OUT_VLD) nxt = TX_LO;
                TX_RD:    if (tx_acc)      nxt = IDLE;
                TX_LO:    if (tx_acc)      nxt = TX_HI;
                TX_HI:    if (tx_acc)      nxt = IDLE;
                default:                   nxt = IDLE;
            endcase
        end
    end

    // Output logic: data-type outputs hold their last value, strobes default low
    always_comb begin
        rf_addr_d    = RF_ADDR;
        rf_wr_data_d = RF_WR_DATA;
        alu_fun_d    = ALU_FUN;
        tx_data_d    = TX_P_DATA;
        tx_vld_d     = TX_D_VLD;
        alu_hi_d     = alu_hi;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        alu_en_d     = 1'b0;
        cmd_err_d    = 1'b0;
        gate_d       = (nxt == OP_FUN) || (nxt == ALU_WAIT);
        if (abort) begin
            cmd_err_d = 1'b1;
            tx_vld_d  = 1'b0;
        end else begin
            case (state)
                WR_DATA: if (byte_ok) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = wr_addr;
                    rf_wr_data_d = RX_P_DATA;
                end
                RD_ADDR: if (byte_ok) begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = RX_P_DATA[ADDR_W-1:0];
                end
                OP_A: if (byte_ok) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_W'(OPA_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                end
                OP_B: if (byte_ok) begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_W'(OPB_ADDR);
                    rf_wr_data_d = RX_P_DATA;
                end
                OP_FUN: if (byte_ok) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = RX_P_DATA[FUN_W-1:0];
                end
                RD_WAIT: if (RF_RD_VLD) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = RF_RD_DATA;
                end
                ALU_WAIT: if (ALU_OUT_VLD) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = ALU_OUT[DATA_W-1:0];
                    alu_hi_d  = ALU_OUT[2*DATA_W-1:DATA_W];
                end
                TX_RD: if (tx_acc) tx_vld_d = 1'b0;
                // Low byte accepted: present the high byte straight away
                TX_LO: if (tx_acc) tx_data_d = alu_hi;
                TX_HI: if (tx_acc) tx_vld_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Output register
    always_ff @(posedge CLK) begin
        if (RST) begin
            RF_ADDR     <= '0;
            RF_WR_EN    <= 1'b0;
            RF_WR_DATA  <= '0;
            RF_RD_EN    <= 1'b0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            CMD_ERR     <= 1'b0;
            alu_hi      <= '0;
        end else begin
            RF_ADDR     <= rf_addr_d;
            RF_WR_EN    <= rf_wr_en_d;
            RF_WR_DATA  <= rf_wr_data_d;
            RF_RD_EN    <= rf_rd_en_d;
            ALU_EN      <= alu_en_d;
            ALU_FUN     <= alu_fun_d;
            CLK_GATE_EN <= gate_d;
            TX_P_DATA   <= tx_data_d;
            TX_D_VLD    <= tx_vld_d;
            CMD_ERR     <= cmd_err_d;
            alu_hi      <= alu_hi_d;
        end
    end

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Directed bench for sys_ctrl_rx: inputs change 1ns after each rising edge,
// outputs are checked at that same point against hand-computed values.
module tb_sys_ctrl_rx;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD, RX_ERR;
    logic [3:0]  RF_ADDR;
    logic        RF_WR_EN, RF_RD_EN, RF_RD_VLD;
    logic [7:0]  RF_WR_DATA, RF_RD_DATA;
    logic        ALU_EN, ALU_OUT_VLD, CLK_GATE_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD, TX_BUSY, CMD_ERR;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    sys_ctrl_rx dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
        .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
        .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
        .CMD_ERR(CMD_ERR)
    );

    // Every output in one word: {addr, wr_en, wr_data, rd_en, alu_en, fun, gate, tx_data, tx_vld, cmd_err}
    wire [29:0] outs = {RF_ADDR, RF_WR_EN, RF_WR_DATA, RF_RD_EN, ALU_EN, ALU_FUN,
                        CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic err);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        RX_ERR    = err;
        tick();
        RX_D_VLD  = 1'b0;
        RX_ERR    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 0; RX_ERR = 0;
        RF_RD_DATA = '0; RF_RD_VLD = 0; ALU_OUT = '0; ALU_OUT_VLD = 0; TX_BUSY = 0;
        tick(); tick();
        chk("reset_outputs", 32'(outs), 32'h0);
        RST = 1'b0;

        // Write frame AA 05 3C
        send(8'hAA, 0);
        chk("wr_cmd_no_err", {31'b0, CMD_ERR}, 32'h0);
        send(8'h05, 0);
        chk("wr_addr_no_strobe", {31'b0, RF_WR_EN}, 32'h0);
        send(8'h3C, 0);
        chk("wr_strobe", {19'b0, RF_WR_EN, RF_ADDR, RF_WR_DATA}, {19'b0, 1'b1, 4'h5, 8'h3C});
        tick();
        chk("wr_strobe_one_cycle", {30'b0, RF_WR_EN, TX_D_VLD}, 32'h0);

        // Read frame BB 05, data two cycles after the strobe, TX busy for 10 cycles
        send(8'hBB, 0);
        send(8'h05, 0);
        chk("rd_strobe", {27'b0, RF_RD_EN, RF_ADDR}, {27'b0, 1'b1, 4'h5});
        tick();
        chk("rd_strobe_one_cycle", {31'b0, RF_RD_EN}, 32'h0);
        RF_RD_DATA = 8'h3C; RF_RD_VLD = 1'b1; TX_BUSY = 1'b1;
        tick();
        RF_RD_VLD = 1'b0; RF_RD_DATA = 8'h99;
        chk("rd_tx_next_cycle", {23'b0, TX_D_VLD, TX_P_DATA}, {23'b0, 1'b1, 8'h3C});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rd_tx_held_busy", {23'b0, TX_D_VLD, TX_P_DATA}, {23'b0, 1'b1, 8'h3C});
        end
        TX_BUSY = 1'b0;
        tick();
        chk("rd_tx_accepted", {31'b0, TX_D_VLD}, 32'h0);

        // ALU frame CC 07 03 00, result 0x000A
        send(8'hCC, 0);
        chk("op_gate_off", {31'b0, CLK_GATE_EN}, 32'h0);
        send(8'h07, 0);
        chk("op_a_write", {19'b0, RF_WR_EN, RF_ADDR, RF_WR_DATA}, {19'b0, 1'b1, 4'h0, 8'h07});
        send(8'h03, 0);
        chk("op_b_write", {19'b0, RF_WR_EN, RF_ADDR, RF_WR_DATA}, {19'b0, 1'b1, 4'h1, 8'h03});
        chk("gate_on_op_fun", {31'b0, CLK_GATE_EN}, 32'h1);
        send(8'h00, 0);
        chk("alu_strobe", {26'b0, ALU_EN, ALU_FUN, CLK_GATE_EN}, {26'b0, 1'b1, 4'h0, 1'b1});
        tick();
        chk("alu_wait_gate", {30'b0, ALU_EN, CLK_GATE_EN}, 32'h1);
        ALU_OUT = 16'h000A; ALU_OUT_VLD = 1'b1; TX_BUSY = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0; ALU_OUT = 16'hFFFF;
        chk("alu_tx_lo", {22'b0, TX_D_VLD, TX_P_DATA, CLK_GATE_EN}, {22'b0, 1'b1, 8'h0A, 1'b0});
        TX_BUSY = 1'b0;
        tick();
        TX_BUSY = 1'b1;
        chk("alu_tx_hi", {23'b0, TX_D_VLD, TX_P_DATA}, {23'b0, 1'b1, 8'h00});
        tick();
        chk("alu_tx_hi_held", {23'b0, TX_D_VLD, TX_P_DATA}, {23'b0, 1'b1, 8'h00});
        TX_BUSY = 1'b0;
        tick();
        chk("alu_tx_done", {31'b0, TX_D_VLD}, 32'h0);

        // DD 02 with no ALU response: timeout exactly 255 cycles after entry to ALU_WAIT
        send(8'hDD, 0);
        send(8'h02, 0);
        chk("nop_alu_strobe", {27'b0, ALU_EN, ALU_FUN}, {27'b0, 1'b1, 4'h2});
        seen = 1'b0;
        for (int i = 1; i <= 254; i++) begin
            if (i == 10) send(8'hAA, 0);  // stray byte in ALU_WAIT is dropped
            else tick();
            seen = seen | CMD_ERR | RF_WR_EN;
        end
        chk("timeout_not_early", {31'b0, seen}, 32'h0);
        tick();
        chk("timeout_cmd_err", {30'b0, CMD_ERR, CLK_GATE_EN}, {30'b0, 1'b1, 1'b0});
        tick();
        chk("timeout_pulse_one_cycle", {31'b0, CMD_ERR}, 32'h0);

        // AA 05 with RX_ERR on the data byte, then AA 01 FF back-to-back
        send(8'hAA, 0);
        send(8'h05, 0);
        send(8'h3C, 1);
        chk("rx_err_abort", {30'b0, RF_WR_EN, CMD_ERR}, {30'b0, 1'b0, 1'b1});
        send(8'hAA, 0);
        chk("rx_err_pulse_one_cycle", {31'b0, CMD_ERR}, 32'h0);
        send(8'h01, 0);
        send(8'hFF, 0);
        chk("write_after_abort", {19'b0, RF_WR_EN, RF_ADDR, RF_WR_DATA}, {19'b0, 1'b1, 4'h1, 8'hFF});

        // Unknown command byte
        send(8'h55, 0);
        chk("bad_cmd", {28'b0, RF_WR_EN, RF_RD_EN, ALU_EN, CMD_ERR}, 32'h1);

        // Reset during WR_DATA, then the would-be data byte is an unknown command
        send(8'hAA, 0);
        send(8'h05, 0);
        RST = 1'b1;
        tick();
        chk("mid_frame_reset", 32'(outs), 32'h0);
        RST = 1'b0;
        send(8'h3C, 0);
        chk("after_reset_idle", {30'b0, RF_WR_EN, CMD_ERR}, {30'b0, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
